// File: rtl/stump_pkg.sv
// ============================================================================
// Module  : stump_pkg
// Brief   : Shared defaults, FSM state type and PC-index helper for the
//           Stump register bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

package stump_pkg;

    localparam int c_DEF_DATA_W = 16;
    localparam int c_DEF_ADDR_W = 3;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    // The PC lives in the highest-numbered register of the bank.
    function automatic int pc_index(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stump_scoreboard.sv
// ============================================================================
// Module  : stump_scoreboard
// Brief   : Per-register pending bits with issue-set / write-back-clear and
//           busy lookup for two read ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stump_scoreboard #(
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ready,
    input  logic              i_issue_en,
    input  logic [ADDR_W-1:0] i_issue_addr,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_write_addr,
    input  logic [ADDR_W-1:0] i_read_addr_a,
    input  logic [ADDR_W-1:0] i_read_addr_b,
    output logic              o_busy_a,
    output logic              o_busy_b
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] r_pending;
    logic             w_fwd_a;
    logic             w_fwd_b;

    // Set is applied after clear so a same-cycle issue to the same register wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else if (i_ready) begin
            if (i_write_en) begin
                r_pending[i_write_addr] <= 1'b0;
            end
            if (i_issue_en && (i_issue_addr != '0)) begin
                r_pending[i_issue_addr] <= 1'b1;
            end
        end
    end

    assign w_fwd_a  = (BYPASS != 0) && i_ready && i_write_en && (i_write_addr == i_read_addr_a);
    assign w_fwd_b  = (BYPASS != 0) && i_ready && i_write_en && (i_write_addr == i_read_addr_b);
    assign o_busy_a = r_pending[i_read_addr_a] & ~w_fwd_a;
    assign o_busy_b = r_pending[i_read_addr_b] & ~w_fwd_b;

endmodule

`default_nettype wire

// File: rtl/stump_regfile_sb.sv
// ============================================================================
// Module  : stump_regfile_sb
// Brief   : Stump register bank with post-reset clear sequencer, optional
//           write-to-read bypass and RAW-hazard scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stump_regfile_sb
    import stump_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    output logic [DATA_W-1:0] pc,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    input  logic [ADDR_W-1:0] read_addr_c,
    output logic [DATA_W-1:0] read_data_a,
    output logic [DATA_W-1:0] read_data_b,
    output logic [DATA_W-1:0] read_data_c,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int                NREGS      = 1 << ADDR_W;
    localparam int                PC_IDX     = pc_index(ADDR_W);
    localparam logic [ADDR_W-1:0] c_CNT_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_CNT_LAST = ADDR_W'(NREGS - 2);

    rf_state_t         r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_init_done;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic              w_ready;
    logic              w_wr;
    logic [ADDR_W-1:0] w_raddr [3];

    assign w_ready = (r_state == READY);
    assign w_wr    = w_ready & write_en;

    // PC is zeroed by reset itself; the sequencer only walks r1..r(NREGS-2),
    // so registers it has not reached yet keep their previous contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= CLEAR;
            r_cnt          <= c_CNT_ONE;
            r_init_done    <= 1'b0;
            r_regs[0]      <= '0;
            r_regs[PC_IDX] <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_regs[r_cnt] <= '0;
                    r_cnt         <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    if (write_en && (write_addr != '0)) begin
                        r_regs[write_addr] <= write_data;
                    end
                end
                default: begin
                    r_state     <= CLEAR;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    assign w_raddr[0] = read_addr_a;
    assign w_raddr[1] = read_addr_b;
    assign w_raddr[2] = read_addr_c;

    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
        logic [DATA_W-1:0] w_rd;
        always_comb begin
            w_rd = '0;
            if (w_ready && (w_raddr[gi] != '0)) begin
                if ((BYPASS != 0) && w_wr && (write_addr == w_raddr[gi])) begin
                    w_rd = write_data;
                end else begin
                    w_rd = r_regs[w_raddr[gi]];
                end
            end
        end
    end

    assign read_data_a = g_rd[0].w_rd;
    assign read_data_b = g_rd[1].w_rd;
    assign read_data_c = g_rd[2].w_rd;
    assign pc          = r_regs[PC_IDX];
    assign init_done   = r_init_done;

    stump_scoreboard #(
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .i_ready       (w_ready),
        .i_issue_en    (issue_en),
        .i_issue_addr  (issue_addr),
        .i_write_en    (write_en),
        .i_write_addr  (write_addr),
        .i_read_addr_a (read_addr_a),
        .i_read_addr_b (read_addr_b),
        .o_busy_a      (busy_a),
        .o_busy_b      (busy_b)
    );

endmodule

`default_nettype wire

// File: tb/tb_stump_regfile_sb.sv
// ============================================================================
// Module  : tb_stump_regfile_sb
// Brief   : Directed bench for stump_regfile_sb (BYPASS=1, BYPASS=0, 32x16).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stump_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 16-bit / 8-register instances
    logic        rst, we, ie;
    logic [2:0]  wa, ia, raa, rab, rac;
    logic [15:0] wd;

    logic        d0_done, d0_ba, d0_bb, d1_done, d1_ba, d1_bb;
    logic [15:0] d0_pc, d0_ra, d0_rb, d0_rc, d1_pc, d1_ra, d1_rb, d1_rc;

    // 32-bit / 16-register instance
    logic        rst2, we2, ie2;
    logic [3:0]  wa2, ia2, raa2, rab2, rac2;
    logic [31:0] wd2;
    logic        d2_done, d2_ba, d2_bb;
    logic [31:0] d2_pc, d2_ra, d2_rb, d2_rc;

    stump_regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .init_done(d0_done), .pc(d0_pc),
        .write_en(we), .write_addr(wa), .write_data(wd),
        .issue_en(ie), .issue_addr(ia),
        .read_addr_a(raa), .read_addr_b(rab), .read_addr_c(rac),
        .read_data_a(d0_ra), .read_data_b(d0_rb), .read_data_c(d0_rc),
        .busy_a(d0_ba), .busy_b(d0_bb)
    );

    stump_regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .init_done(d1_done), .pc(d1_pc),
        .write_en(we), .write_addr(wa), .write_data(wd),
        .issue_en(ie), .issue_addr(ia),
        .read_addr_a(raa), .read_addr_b(rab), .read_addr_c(rac),
        .read_data_a(d1_ra), .read_data_b(d1_rb), .read_data_c(d1_rc),
        .busy_a(d1_ba), .busy_b(d1_bb)
    );

    stump_regfile_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(1)) dut2 (
        .clk(clk), .rst(rst2), .init_done(d2_done), .pc(d2_pc),
        .write_en(we2), .write_addr(wa2), .write_data(wd2),
        .issue_en(ie2), .issue_addr(ia2),
        .read_addr_a(raa2), .read_addr_b(rab2), .read_addr_c(rac2),
        .read_data_a(d2_ra), .read_data_b(d2_rb), .read_data_c(d2_rc),
        .busy_a(d2_ba), .busy_b(d2_bb)
    );

    string       q_tag [$];
    logic [31:0] q_val [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          edges;

    task automatic push(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_val.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_tests++;
        if (q_val.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: observed %h required <none>", obs);
            return;
        end
        t = q_tag.pop_front();
        e = q_val.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", t, obs, e);
        end
    endtask

    task automatic wait_done0(output int n);
        n = 0;
        while (!d0_done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; ie = 1'b0; wa = '0; ia = '0; wd = '0;
        raa = '0; rab = '0; rac = '0;
        rst2 = 1'b1; we2 = 1'b0; ie2 = 1'b0; wa2 = '0; ia2 = '0; wd2 = '0;
        raa2 = '0; rab2 = '0; rac2 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        push("rst_done0", 0); push("rst_pc0", 0); push("rst_ra0", 0);
        push("rst_bb0", 0);   push("rst_done1", 0);
        #1;
        check(d0_done); check(d0_pc); check(d0_ra); check(d0_bb); check(d1_done);
        rst = 1'b0;
        wait_done0(edges);
        push("clear_edges_first", 6);
        check(edges);

        // Preload r1..r7 with all-ones
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 3'(i); wd = 16'hFFFF;
        end
        @(negedge clk);
        we = 1'b0; raa = 3'd4; rac = 3'd6;
        push("preload_pc", 16'hFFFF); push("preload_ra0", 16'hFFFF);
        push("preload_ra1", 16'hFFFF); push("preload_rc0", 16'hFFFF);
        #1;
        check(d0_pc); check(d0_ra); check(d1_ra); check(d0_rc);

        // One-cycle reset pulse; writes and issues during CLEAR must be ignored
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push("pulse_pc0", 0); push("pulse_pc1", 0); push("pulse_done", 0);
        push("clear_ra_zero", 0);
        #1;
        check(d0_pc); check(d1_pc); check(d0_done); check(d0_ra);
        we = 1'b1; wa = 3'd7; wd = 16'h1111; ie = 1'b1; ia = 3'd5;
        wait_done0(edges);
        we = 1'b0; ie = 1'b0;
        push("clear_edges", 6); push("clear_done1", 1);
        push("clear_pc_kept0", 0); push("clear_pc_kept1", 0); push("clear_rc6", 0);
        check(edges); check(d1_done); check(d0_pc); check(d1_pc); check(d0_rc);

        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            raa = 3'(i); rab = 3'(i);
            push($sformatf("cleared_r%0d_d0", i), 0);
            push($sformatf("cleared_r%0d_d1", i), 0);
            push($sformatf("clear_busy_r%0d", i), 0);
            #1;
            check(d0_ra); check(d1_ra); check(d0_bb);
        end

        // R0 reads zero even when written
        @(negedge clk);
        we = 1'b1; wa = 3'd0; wd = 16'h1234; raa = 3'd0;
        push("r0_same_d0", 0); push("r0_same_d1", 0);
        #1;
        check(d0_ra); check(d1_ra);
        @(negedge clk);
        we = 1'b0;
        push("r0_after", 0);
        #1;
        check(d0_ra);

        // PC write
        @(negedge clk);
        we = 1'b1; wa = 3'd7; wd = 16'h0040;
        @(negedge clk);
        we = 1'b0;
        push("pc_write0", 16'h0040); push("pc_write1", 16'h0040);
        #1;
        check(d0_pc); check(d1_pc);

        // Same-cycle bypass versus registered visibility
        @(negedge clk);
        we = 1'b1; wa = 3'd3; wd = 16'hBEEF; raa = 3'd3;
        push("bypass_on", 16'hBEEF); push("bypass_off_old", 0);
        #1;
        check(d0_ra); check(d1_ra);
        @(negedge clk);
        we = 1'b0;
        push("bypass_on_next", 16'hBEEF); push("bypass_off_next", 16'hBEEF);
        #1;
        check(d0_ra); check(d1_ra);

        // Scoreboard: issue, busy next cycle, write-back clears
        @(negedge clk);
        ie = 1'b1; ia = 3'd5; raa = 3'd5; rab = 3'd5;
        push("sb_issue_cycle", 0);
        #1;
        check(d0_bb);
        @(negedge clk);
        ie = 1'b0;
        push("sb_busy_b0", 1); push("sb_busy_b1", 1); push("sb_busy_a0", 1);
        #1;
        check(d0_bb); check(d1_bb); check(d0_ba);
        @(negedge clk);
        we = 1'b1; wa = 3'd5; wd = 16'h5555;
        push("sb_wb_bypass", 0); push("sb_wb_nobypass", 1);
        #1;
        check(d0_bb); check(d1_bb);
        @(negedge clk);
        we = 1'b0;
        push("sb_after_wb0", 0); push("sb_after_wb1", 0);
        #1;
        check(d0_bb); check(d1_bb);

        // Same-cycle issue and write-back: set wins
        @(negedge clk);
        ie = 1'b1; ia = 3'd5;
        @(negedge clk);
        we = 1'b1; wa = 3'd5; wd = 16'h6666;
        push("sb_both_cycle1", 1);
        #1;
        check(d1_bb);
        @(negedge clk);
        ie = 1'b0; we = 1'b0;
        push("sb_set_wins0", 1); push("sb_set_wins1", 1); push("sb_both_data", 16'h6666);
        #1;
        check(d0_bb); check(d1_bb); check(d0_rb);

        // Reset three edges into CLEAR restarts the sequence
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push("midclr_done", 0);
        #1;
        check(d0_done);
        wait_done0(edges);
        push("midclr_edges", 6); push("midclr_bb0", 0); push("midclr_ba0", 0);
        push("midclr_bb1", 0);   push("midclr_pc", 0);
        check(edges); check(d0_bb); check(d0_ba); check(d1_bb); check(d0_pc);

        // Width sweep: 32-bit data, 16 registers
        @(negedge clk);
        rst2 = 1'b0;
        edges = 0;
        while (!d2_done && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        push("wide_clear_edges", 14);
        check(edges);
        @(negedge clk);
        we2 = 1'b1; wa2 = 4'd15; wd2 = 32'hDEADBEEF;
        @(negedge clk);
        we2 = 1'b0; raa2 = 4'd15; rab2 = 4'd14;
        push("wide_pc", 32'hDEADBEEF); push("wide_ra", 32'hDEADBEEF); push("wide_rb", 0);
        #1;
        check(d2_pc); check(d2_ra); check(d2_rb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stump_regfile_sb.md
# stump_regfile_sb

Parametrised Stump register bank for the pipelined datapath. It keeps the R0-reads-zero and R(N-1)-is-PC conventions. It adds three things: a post-reset clearing sequencer that zeroes every general register, optional same-cycle write-to-read bypass, and a per-register pending scoreboard that lets the issue stage detect read-after-write hazards. Three read ports (A, B, C) are provided; port C serves debug observability.

## Interface
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W; legal range 2..5.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- init_done  out  1  high once the clearing sequence is complete.
- pc  out  DATA_W  contents of r[NREGS-1].
- write_en  in  1  write-back enable.
- write_addr  in  ADDR_W  write-back destination.
- write_data  in  DATA_W  write-back data.
- issue_en  in  1  marks issue_addr pending (an instruction in flight will write it).
- issue_addr  in  ADDR_W  destination of the issuing instruction.
- read_addr_a / read_addr_b / read_addr_c  in  ADDR_W  read addresses.
- read_data_a / read_data_b / read_data_c  out  DATA_W  read data.
- busy_a / busy_b  out  1  the register addressed by port A/B has a write outstanding.

## Operation
- FSM states: CLEAR and READY.
- While rst is high:
  - state=CLEAR, cnt=1.
  - r[NREGS-1] (PC) <= 0.
  - All pending bits <= 0.
- CLEAR with rst low:
  - Each cycle: r[cnt] <= 0, cnt <= cnt+1.
  - When cnt==NREGS-2 the write still happens, then the next state is READY.
  - For NREGS==4 only r1 and r2 are cleared.
  - In CLEAR: write_en and issue_en are ignored, all read_data = 0, busy = 0, init_done = 0.
- READY:
  - init_done = 1.
  - Writes with write_en && write_addr!=0 update r[write_addr] at the clock edge. A write to NREGS-1 updates the PC.
- Reads are combinational:
  - Address 0 returns 0.
  - Otherwise r[addr], unless BYPASS=1, write_en=1 and write_addr==addr!=0. In that case the port returns write_data.
- Scoreboard (READY only):
  - issue_en && issue_addr!=0 sets pending[issue_addr].
  - write_en clears pending[write_addr].
  - Same address in the same cycle: set wins.
- busy_x = pending[read_addr_x] & ~(BYPASS & write_en & write_addr==read_addr_x).
- busy is always 0 for address 0.
- rst asserted mid-operation, including mid-CLEAR, restarts the sequence from cnt=1. Register contents not yet cleared keep their old values until the sequencer reaches them.

## Timing
- Reset values:
  - init_done=0, pc=0, busy_a=busy_b=0, read_data_*=0.
  - Reset values hold in the cycle after rst is sampled high and through CLEAR.
- init_done rises NREGS-2 rising edges after the first edge with rst low. For ADDR_W=3 that is 6 edges.
- Write latency is 1 cycle. With BYPASS=0, data is visible on the read ports the cycle after write_en.
- Scoreboard latency is 1 cycle. busy reflects an issue_en from the previous cycle.
- No handshake and no backpressure: every enabled write in READY is accepted.

## Structure
- Package stump_pkg holds:
  - the default DATA_W and ADDR_W;
  - the FSM state enum rf_state_t {CLEAR, READY};
  - the helper constant for the PC index, NREGS-1.
- Sub-module stump_scoreboard holds the pending vector plus the set/clear and busy logic, parametrised by ADDR_W and BYPASS.
- The storage array, clear sequencer and read muxes live in the top module.

## Test plan
- Reset and clear:
  - Preload r1..r7 with 16'hFFFF, then pulse rst for 1 cycle.
  - Required: pc=0 immediately; init_done=0 for 6 edges, then 1; all of r1..r6 read 0.
  - Writes attempted during CLEAR are ignored.
- R0 and PC:
  - Write 16'h1234 to address 0: port A at address 0 still reads 0.
  - Write 16'h0040 to address 7: pc=16'h0040 the next cycle.
- Bypass:
  - BYPASS=1: write 16'hBEEF to r3 with read_addr_a=3 in the same cycle; read_data_a=16'hBEEF in that cycle.
  - BYPASS=0: read_data_a shows the old value, then 16'hBEEF one cycle later.
- Scoreboard:
  - issue_en to r5, then read_addr_b=5: busy_b=1 the next cycle.
  - Write-back of r5: busy_b=0 in that cycle when BYPASS=1, and 0 afterwards.
  - issue_en and write_en to r5 in the same cycle: busy_b stays 1.
- Mid-clear reset:
  - Assert rst 3 cycles into CLEAR.
  - Required: the sequence restarts, init_done rises 6 edges after rst is released, and pending stays all-zero.
- Width sweep:
  - DATA_W=32, ADDR_W=4: the clear takes 14 cycles.
  - Write 32'hDEADBEEF to r15: pc=32'hDEADBEEF.
